// File: rtl/instr_cache_refill_ctrl_if.sv
// L2-side and cache-set-side signals of the I-cache refill sequencer.
// master = the refill controller, slave = the L2/fetch/cache-set environment.
interface instr_cache_refill_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              ic_miss_i;
    logic [ADDR_W-1:0] miss_addr_i;
    logic              flush_i;
    logic              l2_req_o;
    logic [ADDR_W-1:0] l2_addr_o;
    logic              l2_req_ready_i;
    logic              l2_rvalid_i;
    logic [63:0]       l2_rdata_i;
    logic              ic_repl_grant_o;
    logic [63:0]       rep_word_o;
    logic              refill_done_o;
    logic              ic_stall_o;

    modport master (
        input  ic_miss_i, miss_addr_i, flush_i, l2_req_ready_i, l2_rvalid_i, l2_rdata_i,
        output l2_req_o, l2_addr_o, ic_repl_grant_o, rep_word_o, refill_done_o, ic_stall_o
    );

    modport slave (
        output ic_miss_i, miss_addr_i, flush_i, l2_req_ready_i, l2_rvalid_i, l2_rdata_i,
        input  l2_req_o, l2_addr_o, ic_repl_grant_o, rep_word_o, refill_done_o, ic_stall_o
    );
endinterface

// File: rtl/instr_cache_refill_ctrl.sv
// Buffers a whole L2 block (beats may have gaps), then streams it gap-free to the cache set.
// Request held until L2 ready; stream starts the cycle after the last beat; all outputs registered.
module instr_cache_refill_ctrl #(
    parameter int B      = 64,
    parameter int ADDR_W = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    instr_cache_refill_ctrl_if.master  bus
);
    localparam int BEATS = B / 8;
    localparam int OFF_W = $clog2(B);
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_FILL, S_STREAM, S_DONE, S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rx_q, rx_d, tx_q, tx_d, tx_nxt;
    logic              req_q, req_d, grant_q, grant_d, done_q, done_d, stall_q, stall_d;
    logic [63:0]       word_q, word_d;
    logic              wr_en, last_beat;
    logic [63:0]       blk_buf_q [BEATS];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        grant_d   = 1'b0;
        word_d    = '0;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        tx_nxt    = tx_q + 1'b1;
        last_beat = bus.l2_rvalid_i && (rx_q == LAST);
        case (state_q)
            S_IDLE: begin
                if (bus.ic_miss_i && !bus.flush_i) begin
                    addr_d  = {bus.miss_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
                    rx_d    = '0;
                    tx_d    = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A flush in the accept cycle must still drain, since L2 now owes us a block.
                if (bus.l2_req_ready_i) state_d = bus.flush_i ? S_DRAIN : S_FILL;
                else if (bus.flush_i)   state_d = S_IDLE;
            end
            S_FILL: begin
                if (bus.l2_rvalid_i) begin
                    rx_d  = rx_q + 1'b1;
                    wr_en = !bus.flush_i;
                end
                if (bus.flush_i) begin
                    state_d = last_beat ? S_IDLE : S_DRAIN;
                end else if (last_beat) begin
                    state_d = S_STREAM;
                    tx_d    = '0;
                    grant_d = 1'b1;
                    word_d  = blk_buf_q[0];
                end
            end
            S_STREAM: begin
                if (tx_q == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    tx_d    = tx_nxt;
                    grant_d = 1'b1;
                    word_d  = blk_buf_q[tx_nxt];
                end
            end
            S_DONE: state_d = S_IDLE;
            S_DRAIN: begin
                if (bus.l2_rvalid_i) begin
                    rx_d = rx_q + 1'b1;
                    if (rx_q == LAST) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_d   = (state_d == S_REQ);
        stall_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            req_q   <= 1'b0;
            grant_q <= 1'b0;
            word_q  <= '0;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            req_q   <= req_d;
            grant_q <= grant_d;
            word_q  <= word_d;
            done_q  <= done_d;
            stall_q <= stall_d;
        end
    end

    // Block buffer is data only; its contents are meaningless until a fill completes.
    always_ff @(posedge clk_i) begin
        if (wr_en) blk_buf_q[rx_q] <= bus.l2_rdata_i;
    end

    assign bus.l2_req_o        = req_q;
    assign bus.l2_addr_o       = addr_q;
    assign bus.ic_repl_grant_o = grant_q;
    assign bus.rep_word_o      = word_q;
    assign bus.refill_done_o   = done_q;
    assign bus.ic_stall_o      = stall_q;
endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
// Directed refill scenarios; a negedge monitor checks streamed words against an expected-word queue.
module tb_instr_cache_refill_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_cache_refill_ctrl_if #(.ADDR_W(32)) bus();
    instr_cache_refill_ctrl #(.B(64), .ADDR_W(32)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int done_seen = 0;
    int exp_done = 0;
    logic [63:0] exp_words[$];
    int gap_tbl[8] = '{2, 0, 3, 1, 0, 2, 3, 1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every granted word must match the next expected word; bursts must be 8 long.
    initial begin
        int run_len = 0;
        logic prev_grant = 1'b0, prev_done = 1'b0;
        logic [63:0] w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_len = 0;
                prev_grant = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (bus.ic_repl_grant_o) begin
                    if (exp_words.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL grant_unexpected: grant high with no expected word, word %h at %0t",
                                 bus.rep_word_o, $time);
                    end else begin
                        w = exp_words.pop_front();
                        chk("rep_word", bus.rep_word_o, w);
                    end
                    run_len++;
                end else if (prev_grant) begin
                    chk("burst_len", 64'(run_len), 64'd8);
                    run_len = 0;
                end
                if (bus.refill_done_o) begin
                    done_seen++;
                    chk("done_after_burst", 64'(prev_grant), 64'd1);
                    chk("done_single", 64'(prev_done), 64'd0);
                end
                prev_grant = bus.ic_repl_grant_o;
                prev_done  = bus.refill_done_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Miss, request handshake (ready held low rdy_dly cycles), then 8 beats; returns at first grant.
    task automatic refill(input logic [31:0] a, input logic [63:0] base, input bit gaps, input int rdy_dly);
        logic [31:0] exp_a;
        exp_a = {a[31:6], 6'd0};
        bus.ic_miss_i = 1'b1;
        bus.miss_addr_i = a;
        #1 chk("no_req_in_miss_cycle", 64'(bus.l2_req_o), 64'd0);
        tick();
        bus.ic_miss_i = 1'b0;
        chk("req_asserted", 64'(bus.l2_req_o), 64'd1);
        chk("req_addr", 64'(bus.l2_addr_o), 64'(exp_a));
        for (int i = 0; i < rdy_dly; i++) begin
            bus.l2_rvalid_i = 1'b1;
            bus.l2_rdata_i = 64'hDEAD_0000_0000_0000 + 64'(i);
            tick();
            chk("req_held", 64'(bus.l2_req_o), 64'd1);
            chk("addr_held", 64'(bus.l2_addr_o), 64'(exp_a));
        end
        bus.l2_rvalid_i = 1'b0;
        bus.l2_req_ready_i = 1'b1;
        tick();
        bus.l2_req_ready_i = 1'b0;
        chk("req_dropped", 64'(bus.l2_req_o), 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (gaps) repeat (gap_tbl[i]) tick();
            bus.l2_rvalid_i = 1'b1;
            bus.l2_rdata_i = base + 64'(i);
            exp_words.push_back(base + 64'(i));
            tick();
            bus.l2_rvalid_i = 1'b0;
            if (i < 7) chk("no_early_grant", 64'(bus.ic_repl_grant_o), 64'd0);
        end
        chk("first_grant", 64'(bus.ic_repl_grant_o), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.ic_stall_o && n < 40) begin
            tick();
            n++;
        end
        chk("idle_reached", 64'(bus.ic_stall_o), 64'd0);
    endtask

    initial begin
        bus.ic_miss_i = 1'b0;
        bus.miss_addr_i = '0;
        bus.flush_i = 1'b0;
        bus.l2_req_ready_i = 1'b0;
        bus.l2_rvalid_i = 1'b0;
        bus.l2_rdata_i = '0;
        #12;
        chk("rst_req", 64'(bus.l2_req_o), 64'd0);
        chk("rst_addr", 64'(bus.l2_addr_o), 64'd0);
        chk("rst_grant", 64'(bus.ic_repl_grant_o), 64'd0);
        chk("rst_word", bus.rep_word_o, 64'd0);
        chk("rst_done", 64'(bus.refill_done_o), 64'd0);
        chk("rst_stall", 64'(bus.ic_stall_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: back-to-back beats
        refill(32'h0000_1234, 64'hD000_0000_0000_0000, 1'b0, 0);
        exp_done++;
        wait_idle();

        // 2: gapped beats
        refill(32'h0000_1234, 64'hA100_0000_0000_0000, 1'b1, 0);
        exp_done++;
        wait_idle();

        // 3: L2 not ready for 5 cycles, stray rvalid during REQ ignored
        refill(32'h8000_00FF, 64'hB200_0000_0000_0000, 1'b0, 5);
        exp_done++;
        wait_idle();

        // 4: flush after 3 beats, remaining 5 beats drained, then a normal refill
        bus.ic_miss_i = 1'b1;
        bus.miss_addr_i = 32'h0000_4048;
        tick();
        bus.ic_miss_i = 1'b0;
        bus.l2_req_ready_i = 1'b1;
        tick();
        bus.l2_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.l2_rvalid_i = 1'b1;
            bus.l2_rdata_i = 64'hF000 + 64'(i);
            tick();
        end
        bus.l2_rvalid_i = 1'b0;
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        for (int i = 3; i < 8; i++) begin
            bus.l2_rvalid_i = 1'b1;
            bus.l2_rdata_i = 64'hF000 + 64'(i);
            tick();
            bus.l2_rvalid_i = 1'b0;
            if (i == 6) chk("drain_stall", 64'(bus.ic_stall_o), 64'd1);
        end
        chk("drain_idle", 64'(bus.ic_stall_o), 64'd0);
        refill(32'h0000_4048, 64'hC300_0000_0000_0000, 1'b0, 0);
        exp_done++;
        wait_idle();

        // 5: flush during stream is ignored
        refill(32'h0000_2000, 64'hE400_0000_0000_0000, 1'b0, 0);
        tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        exp_done++;
        wait_idle();

        // 6: reset mid-stream clears outputs asynchronously
        refill(32'h0000_3000, 64'h5500_0000_0000_0000, 1'b0, 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", 64'(bus.ic_repl_grant_o), 64'd0);
        chk("arst_stall", 64'(bus.ic_stall_o), 64'd0);
        chk("arst_req", 64'(bus.l2_req_o), 64'd0);
        exp_words.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 64'(bus.ic_stall_o), 64'd0);
        refill(32'h0000_3040, 64'h6600_0000_0000_0000, 1'b0, 0);
        exp_done++;
        wait_idle();

        repeat (3) tick();
        chk("done_count", 64'(done_seen), 64'(exp_done));
        chk("queue_empty", 64'(exp_words.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
